// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts rising edges of the neuron spike line over a fixed
// window of enabled cycles and publishes rate, running peak and a 7-seg digit.
module spike_rate_decoder #(
  parameter int WINDOW_CYCLES = 1000,
  parameter int RATE_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              spike_in,
  input  logic              clear_peak,
  output logic [RATE_W-1:0] rate_out,
  output logic              rate_valid,
  output logic [RATE_W-1:0] peak_out,
  output logic              silent,
  output logic [6:0]        segments
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  logic [WIN_W-1:0]  win_cnt;
  logic [RATE_W-1:0] spk_cnt;
  logic              spike_q;

  logic              edge_p0;
  logic              win_close_p0;
  logic [RATE_W-1:0] total_p0;

  function automatic logic [RATE_W-1:0] sat_inc(input logic [RATE_W-1:0] cnt,
                                               input logic inc);
    if (inc && (cnt == {RATE_W{1'b1}}))
      return cnt;
    return cnt + RATE_W'(inc);
  endfunction

  function automatic logic [6:0] seg_encode(input logic [RATE_W-1:0] val);
    logic [3:0] nib;
    logic [6:0] pat;
    nib = val[3:0];
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
    if (int'(val) > 15)
      pat = 7'h40;
    return pat;
  endfunction

  // Stage p0: edge detect and the saturated count including this cycle's edge.
  // The edge on a closing cycle belongs to the closing window.
  always_comb begin
    edge_p0      = spike_in & ~spike_q;
    win_close_p0 = ena && (win_cnt == WIN_LAST);
    total_p0     = sat_inc(spk_cnt, edge_p0);
  end

  // Stage p1: window bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt    <= '0;
      spk_cnt    <= '0;
      spike_q    <= 1'b0;
      rate_out   <= '0;
      rate_valid <= 1'b0;
      peak_out   <= '0;
      silent     <= 1'b0;
      segments   <= 7'h3F;
    end else begin
      // spike_q tracks the line even while disabled, so a level already high
      // when ena rises is not mistaken for a fresh spike.
      spike_q    <= spike_in;
      rate_valid <= 1'b0;
      if (ena) begin
        if (win_close_p0) begin
          win_cnt    <= '0;
          spk_cnt    <= '0;
          rate_out   <= total_p0;
          rate_valid <= 1'b1;
          silent     <= (total_p0 == '0);
          segments   <= seg_encode(total_p0);
          if (total_p0 > peak_out)
            peak_out <= total_p0;
        end else begin
          win_cnt <= win_cnt + WIN_W'(1);
          spk_cnt <= total_p0;
        end
      end
      if (clear_peak)
        peak_out <= '0;
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: table of 16-cycle windows checked through a
// rate_valid-driven scoreboard, plus hand-written gating/reset/overflow cases.
module tb_spike_rate_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ena16, ena600, spike_in, clear_peak;
  logic [7:0] a_rate, a_peak, b_rate, b_peak;
  logic       a_valid, a_silent, b_valid, b_silent;
  logic [6:0] a_seg, b_seg;

  spike_rate_decoder #(.WINDOW_CYCLES(16), .RATE_W(8)) dut16 (
    .clk(clk), .rst(rst), .ena(ena16), .spike_in(spike_in), .clear_peak(clear_peak),
    .rate_out(a_rate), .rate_valid(a_valid), .peak_out(a_peak), .silent(a_silent),
    .segments(a_seg)
  );

  spike_rate_decoder #(.WINDOW_CYCLES(600), .RATE_W(8)) dut600 (
    .clk(clk), .rst(rst), .ena(ena600), .spike_in(spike_in), .clear_peak(clear_peak),
    .rate_out(b_rate), .rate_valid(b_valid), .peak_out(b_peak), .silent(b_silent),
    .segments(b_seg)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int cyc;
    int rate;
    int peak;
    int silent;
    int seg;
  } exp_t;

  typedef struct {
    logic [15:0] pat;
    logic        clr;
    int          rate;
    int          peak;
    int          silent;
    int          seg;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[12];

  function automatic void check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (a_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: rate_valid=1 at cycle %0d, required 0", cyc);
      end else begin
        e = sbq.pop_front();
        check("valid_cycle", cyc, e.cyc);
        check("rate_out", int'(a_rate), e.rate);
        check("peak_out", int'(a_peak), e.peak);
        check("silent", int'(a_silent), e.silent);
        check("segments", int'(a_seg), e.seg);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_window(input vec_t v);
    sbq.push_back('{cyc + 16, v.rate, v.peak, v.silent, v.seg});
    for (int i = 0; i < 16; i++) begin
      spike_in   = v.pat[i];
      clear_peak = v.clr && (i == 15);
      step();
    end
    spike_in   = 1'b0;
    clear_peak = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ena16 = 1'b0; ena600 = 1'b0; spike_in = 1'b0; clear_peak = 1'b0;

    //            pattern (bit i = cycle i)  clr   rate peak silent seg
    vecs[0]  = '{16'h0000, 1'b0, 0, 0, 1, 'h3F};
    vecs[1]  = '{16'h0000, 1'b0, 0, 0, 1, 'h3F};
    vecs[2]  = '{16'h0155, 1'b0, 5, 5, 0, 'h6D};
    vecs[3]  = '{16'h00FC, 1'b0, 1, 5, 0, 'h06};
    vecs[4]  = '{16'h8005, 1'b0, 3, 5, 0, 'h4F};
    vecs[5]  = '{16'h0000, 1'b0, 0, 5, 1, 'h3F};
    vecs[6]  = '{16'h1555, 1'b1, 7, 0, 0, 'h07};
    vecs[7]  = '{16'h0005, 1'b0, 2, 2, 0, 'h5B};
    vecs[8]  = '{16'hFFFF, 1'b0, 1, 2, 0, 'h06};
    vecs[9]  = '{16'h5555, 1'b0, 7, 7, 0, 'h07};
    vecs[10] = '{16'hAAAA, 1'b0, 8, 8, 0, 'h7F};
    vecs[11] = '{16'h0000, 1'b0, 0, 8, 1, 'h3F};

    step();
    step();
    check("reset_rate", int'(a_rate), 0);
    check("reset_peak", int'(a_peak), 0);
    check("reset_silent", int'(a_silent), 0);
    check("reset_valid", int'(a_valid), 0);
    check("reset_seg", int'(a_seg), 'h3F);
    rst   = 1'b0;
    ena16 = 1'b1;

    for (int i = 0; i < 12; i++)
      apply_window(vecs[i]);

    // Enable gap of 10 cycles with the line toggling; high level at ena rise.
    sbq.push_back('{cyc + 26, 2, 8, 0, 'h5B});
    for (int i = 0; i < 4; i++) begin
      spike_in = (i == 0) || (i == 2);
      step();
    end
    ena16 = 1'b0;
    for (int g = 0; g < 10; g++) begin
      spike_in = ((g % 2) == 1);
      step();
    end
    check("gap_rate_held", int'(a_rate), 0);
    ena16    = 1'b1;
    spike_in = 1'b1;
    step();
    spike_in = 1'b0;
    for (int i = 0; i < 11; i++)
      step();

    // Reset in the middle of a window holding 4 spikes.
    for (int i = 0; i < 7; i++) begin
      spike_in = ((i % 2) == 0);
      step();
    end
    spike_in = 1'b0;
    rst      = 1'b1;
    step();
    check("midrst_rate", int'(a_rate), 0);
    check("midrst_peak", int'(a_peak), 0);
    check("midrst_silent", int'(a_silent), 0);
    check("midrst_valid", int'(a_valid), 0);
    check("midrst_seg", int'(a_seg), 'h3F);
    rst = 1'b0;
    apply_window('{16'h0001, 1'b0, 1, 1, 0, 'h06});

    // Saturation on the 600-cycle instance: 300 edges in one window.
    ena16 = 1'b0;
    rst   = 1'b1;
    step();
    rst    = 1'b0;
    ena600 = 1'b1;
    for (int i = 0; i < 600; i++) begin
      spike_in = ((i % 2) == 0);
      step();
      if (i == 598)
        check("ovf_valid_early", int'(b_valid), 0);
    end
    spike_in = 1'b0;
    check("ovf_valid", int'(b_valid), 1);
    check("ovf_rate", int'(b_rate), 255);
    check("ovf_peak", int'(b_peak), 255);
    check("ovf_seg", int'(b_seg), 'h40);
    check("ovf_silent", int'(b_silent), 0);
    ena600 = 1'b0;
    step();
    check("ovf_valid_pulse", int'(b_valid), 0);
    check("ovf_rate_hold", int'(b_rate), 255);

    check("sb_drain", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
